// File: rtl/main_mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// main_mem_ctrl_pkg
// Shared definitions for the main-memory controller slice:
//   - default geometry (byte-address width, word width) and default latency
//   - controller state encoding
//   - saturating 16-bit increment used by the optional statistics counters
// No ports; imported by main_mem_ctrl and main_mem_ctrl_mem_array.
// -----------------------------------------------------------------------------
package main_mem_ctrl_pkg;

    // Byte-address width of the main memory.
    localparam int MEM_ADDR_SIZE = 10;
    // Word width in bits.
    localparam int WORD_SIZE_BIT = 32;
    // Default request-accept to done-pulse latency (legal 1..15).
    localparam int MEM_LATENCY   = 4;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_DONE    = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/main_mem_ctrl_mem_array.sv
// -----------------------------------------------------------------------------
// main_mem_ctrl_mem_array
// Single-port synchronous word RAM behind the controller FSM.
// The storage is not reset; it starts at zero for simulation. The read-data
// register is reset to zero and only updates on a read strobe, so it holds the
// last read word until the next read.
//
// Ports:
//   clock  in   rising-edge clock
//   reset  in   asynchronous active-low reset (read-data register only)
//   we     in   write strobe: mem[idx] <= wdata
//   re     in   read strobe:  rdata <= mem[idx]
//   idx    in   word index
//   wdata  in   write data
//   rdata  out  registered read data
// -----------------------------------------------------------------------------
module main_mem_ctrl_mem_array
    import main_mem_ctrl_pkg::*;
#(
    parameter int IDX_W  = MEM_ADDR_SIZE - 2,
    parameter int DATA_W = WORD_SIZE_BIT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << IDX_W;

    // Storage; zero at time 0 for simulation, never reset.
    logic [DATA_W-1:0] mem_r [DEPTH] = '{default: '0};
    logic [DATA_W-1:0] rdata_r;

    // Write port: commit one word per write strobe.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[idx] <= wdata;
        end else begin
            mem_r[idx] <= mem_r[idx];
        end
    end

    // Read-data register: loads only on a read strobe, holds otherwise.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata_r <= {DATA_W{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[idx];
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/main_mem_ctrl.sv
// -----------------------------------------------------------------------------
// main_mem_ctrl
// Fixed-latency main-memory controller sitting below the direct-mapped data
// cache. Accepts one level-signalled read or write at a time (read wins when
// both are high), waits LATENCY cycles, then commits the access and pulses
// done_r or done_w for one cycle. A request still held after completion is
// parked in RELEASE until both request lines drop, so it is not re-accepted.
//
// Optional feature (macro MEM_STATS_EN): adds rd_count/wr_count, saturating
// 16-bit completion counters cleared by reset.
//
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   read      in   read request (level), sampled only in IDLE
//   write     in   write request (level), sampled only in IDLE
//   addr      in   byte address, bits [1:0] ignored
//   wData     in   write data
//   memData   out  registered read data, held until the next read completes
//   done_r    out  one-cycle read-complete pulse
//   done_w    out  one-cycle write-complete pulse
//   rd_count  out  (MEM_STATS_EN) completed reads, saturating
//   wr_count  out  (MEM_STATS_EN) completed writes, saturating
// -----------------------------------------------------------------------------
module main_mem_ctrl
    import main_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W  = MEM_ADDR_SIZE,
    parameter int DATA_W  = WORD_SIZE_BIT,
    parameter int LATENCY = MEM_LATENCY
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wData,
    output logic [DATA_W-1:0] memData,
    output logic              done_r,
    output logic              done_w
`ifdef MEM_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    localparam int         IDX_W       = ADDR_W - 2;
    localparam logic [3:0] LAT_LOAD    = 4'(LATENCY - 1);
    // With a one-cycle latency the accept edge is also the DONE entry edge.
    localparam bit         DIRECT_DONE = (LAT_LOAD == 4'd0);

    state_e              state_r, state_s;
    logic [3:0]          cnt_r, cnt_s;
    logic [IDX_W-1:0]    idx_r, idx_s;
    logic [DATA_W-1:0]   wdata_r, wdata_s;
    logic                is_rd_r, is_rd_s;
    logic                enter_done_s;
    logic                mem_we_s;
    logic                mem_re_s;
    logic                done_rd_r;
    logic                done_wr_r;
    logic                addr_unused_s;

    // Byte-offset bits carry no information for a word-addressed memory.
    assign addr_unused_s = ^addr[1:0];

    // Next-state, counter and request-latch logic.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        idx_s        = idx_r;
        wdata_s      = wdata_r;
        is_rd_s      = is_rd_r;
        enter_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (read || write) begin
                    idx_s   = addr[ADDR_W-1:2];
                    wdata_s = wData;
                    // Read wins; a simultaneous write is dropped.
                    is_rd_s = read;
                    if (DIRECT_DONE) begin
                        cnt_s        = 4'd0;
                        state_s      = ST_DONE;
                        enter_done_s = 1'b1;
                    end else begin
                        cnt_s   = LAT_LOAD;
                        state_s = ST_BUSY;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == 4'd0) begin
                    state_s      = ST_DONE;
                    enter_done_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_DONE: begin
                // Only the line that was accepted decides whether to park.
                if (is_rd_r ? read : write) begin
                    state_s = ST_RELEASE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RELEASE: begin
                if (!read && !write) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RELEASE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // The memory access happens on the DONE entry edge using the request as it
    // will be latched on that edge (covers the direct IDLE->DONE case).
    assign mem_re_s = enter_done_s & is_rd_s;
    assign mem_we_s = enter_done_s & ~is_rd_s;

    // Control state and latched request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            idx_r   <= {IDX_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            is_rd_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            wdata_r <= wdata_s;
            is_rd_r <= is_rd_s;
        end
    end

    // Completion pulses: high exactly for the DONE cycle, never both at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            done_rd_r <= 1'b0;
            done_wr_r <= 1'b0;
        end else begin
            done_rd_r <= mem_re_s;
            done_wr_r <= mem_we_s;
        end
    end

    assign done_r = done_rd_r;
    assign done_w = done_wr_r;

    main_mem_ctrl_mem_array #(
        .IDX_W  (IDX_W),
        .DATA_W (DATA_W)
    ) u_mem_array (
        .clock (clock),
        .reset (reset),
        .we    (mem_we_s),
        .re    (mem_re_s),
        .idx   (idx_s),
        .wdata (wdata_s),
        .rdata (memData)
    );

`ifdef MEM_STATS_EN
    logic [15:0] rd_count_r;
    logic [15:0] wr_count_r;

    // Completion counters, advanced on the same edge that raises done.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_count_r <= 16'd0;
            wr_count_r <= 16'd0;
        end else begin
            if (mem_re_s) begin
                rd_count_r <= sat_inc16(rd_count_r);
            end else begin
                rd_count_r <= rd_count_r;
            end
            if (mem_we_s) begin
                wr_count_r <= sat_inc16(wr_count_r);
            end else begin
                wr_count_r <= wr_count_r;
            end
        end
    end

    assign rd_count = rd_count_r;
    assign wr_count = wr_count_r;
`endif

endmodule

// File: tb/tb_main_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_main_mem_ctrl
// Directed-vector bench for main_mem_ctrl (default LATENCY = 4). Every request
// is followed cycle by cycle: done_r/done_w must be low except at the fourth
// edge after accept, and memData must hold its previous value until a read
// completes. Stats ports are exercised when MEM_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_main_mem_ctrl;

    localparam int LAT = 4;

    logic        clock;
    logic        reset;
    logic        read;
    logic        write;
    logic [9:0]  addr;
    logic [31:0] wData;
    logic [31:0] memData;
    logic        done_r;
    logic        done_w;
`ifdef MEM_STATS_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    int          n_vec;
    int          n_err;
    int          both_cnt;
    logic [31:0] md_exp;

    main_mem_ctrl dut (
        .clock   (clock),
        .reset   (reset),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wData   (wData),
        .memData (memData),
        .done_r  (done_r),
        .done_w  (done_w)
`ifdef MEM_STATS_EN
        ,
        .rd_count(rd_count),
        .wr_count(wr_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Watch for the two completion pulses ever overlapping.
    always @(negedge clock) begin
        if (done_r && done_w) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one request, keep its lines high for 'hold' sampled edges, and
    // check every cycle up to well past any possible re-acceptance.
    task automatic run_req(input string tag, input logic rd, input logic wr,
                           input logic [9:0] a, input logic [31:0] d,
                           input int hold, input logic [31:0] rd_val);
        logic exp_dr;
        logic exp_dw;
        exp_dr = rd;
        exp_dw = wr & ~rd;
        read   = rd;
        write  = wr;
        addr   = a;
        wData  = d;
        tick();                                   // accept edge E0
        for (int k = 1; k <= 2*LAT + 4; k++) begin
            if (k == hold) begin
                read  = 1'b0;
                write = 1'b0;
                addr  = 10'h3FC;
                wData = 32'hFFFF_FFFF;
            end
            tick();                               // edge Ek
            if (k == LAT && rd) md_exp = rd_val;
            chk($sformatf("%s.done_r@%0d", tag, k), {31'd0, done_r},
                {31'd0, (k == LAT) ? exp_dr : 1'b0});
            chk($sformatf("%s.done_w@%0d", tag, k), {31'd0, done_w},
                {31'd0, (k == LAT) ? exp_dw : 1'b0});
            chk($sformatf("%s.memData@%0d", tag, k), memData, md_exp);
        end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        both_cnt = 0;
        md_exp   = 32'd0;
        reset    = 1'b0;
        read     = 1'b0;
        write    = 1'b0;
        addr     = 10'h000;
        wData    = 32'd0;

        // Reset state
        tick();
        tick();
        chk("rst.memData", memData, 32'd0);
        chk("rst.done_r", {31'd0, done_r}, 32'd0);
        chk("rst.done_w", {31'd0, done_w}, 32'd0);
`ifdef MEM_STATS_EN
        chk("rst.rd_count", {16'd0, rd_count}, 32'd0);
        chk("rst.wr_count", {16'd0, wr_count}, 32'd0);
`endif
        reset = 1'b1;
        tick();

        // Read of untouched memory, request held two edges
        run_req("rd040", 1'b1, 1'b0, 10'h040, 32'd0, 2, 32'd0);
        // Write, then read it back; write must not disturb memData
        run_req("wr044", 1'b0, 1'b1, 10'h044, 32'hDEAD_BEEF, 1, 32'd0);
        run_req("rd044", 1'b1, 1'b0, 10'h044, 32'd0, 1, 32'hDEAD_BEEF);
        run_req("wr044b", 1'b0, 1'b1, 10'h044, 32'h0000_1234, 1, 32'd0);

        // Line fill: preload, then reads held through RELEASE
        run_req("wr080", 1'b0, 1'b1, 10'h080, 32'd1, 1, 32'd0);
        run_req("wr084", 1'b0, 1'b1, 10'h084, 32'd2, 1, 32'd0);
        run_req("wr088", 1'b0, 1'b1, 10'h088, 32'd3, 1, 32'd0);
        run_req("wr08C", 1'b0, 1'b1, 10'h08C, 32'd4, 1, 32'd0);
        run_req("fill0", 1'b1, 1'b0, 10'h080, 32'd0, 8, 32'd1);
        run_req("fill1", 1'b1, 1'b0, 10'h084, 32'd0, 8, 32'd2);
        run_req("fill2", 1'b1, 1'b0, 10'h088, 32'd0, 8, 32'd3);
        run_req("fill3", 1'b1, 1'b0, 10'h08C, 32'd0, 8, 32'd4);

        // Simultaneous read and write: read wins, write dropped
        run_req("rdwr010", 1'b1, 1'b1, 10'h010, 32'h5, 1, 32'd0);
        run_req("rd010", 1'b1, 1'b0, 10'h010, 32'd0, 1, 32'd0);
        run_req("rd044c", 1'b1, 1'b0, 10'h044, 32'd0, 1, 32'h0000_1234);

        // Reset in the middle of a write
        read  = 1'b0;
        write = 1'b1;
        addr  = 10'h020;
        wData = 32'hA5A5_A5A5;
        tick();                                   // accept
        write = 1'b0;
        tick();
        tick();                                   // still BUSY
        reset = 1'b0;
        #1;
        md_exp = 32'd0;
        chk("mrst.async_memData", memData, 32'd0);
        chk("mrst.async_done_w", {31'd0, done_w}, 32'd0);
        tick();
        chk("mrst.hold_done_w", {31'd0, done_w}, 32'd0);
        reset = 1'b1;
        for (int k = 0; k < LAT + 2; k++) begin
            tick();
            chk($sformatf("mrst.done_w@%0d", k), {31'd0, done_w}, 32'd0);
            chk($sformatf("mrst.done_r@%0d", k), {31'd0, done_r}, 32'd0);
        end

        // Three reads and two writes since the last reset
        run_req("wr100", 1'b0, 1'b1, 10'h100, 32'h11, 1, 32'd0);
        run_req("wr104", 1'b0, 1'b1, 10'h104, 32'h22, 1, 32'd0);
        run_req("rd100", 1'b1, 1'b0, 10'h100, 32'd0, 1, 32'h11);
        run_req("rd104", 1'b1, 1'b0, 10'h104, 32'd0, 1, 32'h22);
        run_req("rd020", 1'b1, 1'b0, 10'h020, 32'd0, 1, 32'd0);
`ifdef MEM_STATS_EN
        chk("stats.rd_count", {16'd0, rd_count}, 32'd3);
        chk("stats.wr_count", {16'd0, wr_count}, 32'd2);
        reset = 1'b0;
        #1;
        chk("stats.rd_count_rst", {16'd0, rd_count}, 32'd0);
        chk("stats.wr_count_rst", {16'd0, wr_count}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
`endif

        chk("excl.done_both", both_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
